fetch_queue_ctrl: RTL and testbench

Prefetch controller that sequences the synchronous instruction ROM and buffers fetched instructions for the backend. It owns the fetch PC, issues ROM reads ahead of consumption into a DEPTH-entry queue, and presents the queue head on the deque/restart handshake the backend consumes. A restart (taken branch/jump) flushes the queue, discards any in-flight read and redirects the PC.

---
 rtl/fetch_queue_ctrl.sv | 132 +++++++++++++
 tb/tb_fetch_queue_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_ctrl.sv
// fetch_queue_ctrl
// ----------------
// Prefetch controller between a synchronous instruction ROM and the backend.
// It owns the fetch PC and issues ROM reads ahead of consumption. Returned
// words are buffered with their addresses in a DEPTH-entry circular queue.
// The queue head is presented to the backend, which pops it with deque_i.
// restart_i flushes the queue, drops any in-flight read and redirects the PC.
//
// Ports
//   clk                 rising-edge clock
//   reset_n_i           asynchronous active-low reset
//   deque_i             backend consumes the head entry this cycle
//   restart_i           flush queue and redirect fetch to restart_addr_i
//   restart_addr_i      redirect target address
//   instruction_data_o  head instruction word (registered storage)
//   instruction_addr_o  head instruction address (registered storage)
//   instruction_ready_o head entry valid
//   rom_en_o            ROM read strobe
//   rom_addr_o          ROM read address (current fetch PC)
//   rom_data_i          ROM read data, valid the cycle after rom_en_o
//   count_o             queue occupancy
module fetch_queue_ctrl #(
    parameter int I_WIDTH = 12,
    parameter int A_WIDTH = 8,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     reset_n_i,
    input  logic                     deque_i,
    input  logic                     restart_i,
    input  logic [A_WIDTH-1:0]       restart_addr_i,
    output logic [I_WIDTH-1:0]       instruction_data_o,
    output logic [A_WIDTH-1:0]       instruction_addr_o,
    output logic                     instruction_ready_o,
    output logic                     rom_en_o,
    output logic [A_WIDTH-1:0]       rom_addr_o,
    input  logic [I_WIDTH-1:0]       rom_data_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [A_WIDTH-1:0] pc_reg;
    logic [A_WIDTH-1:0] resp_addr_reg;
    logic               inflight_reg;
    logic [CW-1:0]      count_reg;
    logic [CW-1:0]      count_next;
    logic [PW-1:0]      head_reg;
    logic [PW-1:0]      tail_reg;

    logic [A_WIDTH-1:0] addr_mem [DEPTH];
    logic [I_WIDTH-1:0] data_mem [DEPTH];

    // One extra bit so count + inflight can reach DEPTH without wrapping.
    logic [CW:0] fill;
    logic        issue;
    logic        push;
    logic        pop;

    // Issue is gated by the registered occupancy only; a pop in the same
    // cycle is deliberately not credited, which keeps rom_en_o free of any
    // dependency on deque_i.
    always_comb begin
        fill  = {1'b0, count_reg} + {{CW{1'b0}}, inflight_reg};
        issue = reset_n_i & ~restart_i & (fill < (CW+1)'(DEPTH));
        push  = inflight_reg & ~restart_i;
        pop   = deque_i & (count_reg != '0) & ~restart_i;
    end

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (pop && !push) begin
            count_next = count_reg - 1'b1;
        end
    end

    // Control state: PC, in-flight tracking, pointers, occupancy.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pc_reg        <= '0;
            resp_addr_reg <= '0;
            inflight_reg  <= 1'b0;
            count_reg     <= '0;
            head_reg      <= '0;
            tail_reg      <= '0;
        end else if (restart_i) begin
            // Any response arriving next cycle belongs to the old stream.
            pc_reg       <= restart_addr_i;
            inflight_reg <= 1'b0;
            count_reg    <= '0;
            head_reg     <= '0;
            tail_reg     <= '0;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                resp_addr_reg <= pc_reg;
                pc_reg        <= pc_reg + 1'b1;
            end
            if (push) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (pop) begin
                head_reg <= head_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    // Queue storage: written at the tail when a response returns.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else if (push) begin
            addr_mem[tail_reg] <= resp_addr_reg;
            data_mem[tail_reg] <= rom_data_i;
        end
    end

    assign rom_en_o            = issue;
    assign rom_addr_o          = pc_reg;
    assign instruction_ready_o = (count_reg != '0);
    assign instruction_data_o  = data_mem[head_reg];
    assign instruction_addr_o  = addr_mem[head_reg];
    assign count_o             = count_reg;

endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// Testbench for fetch_queue_ctrl: directed stimulus, with delivered
// instructions checked by a scoreboard monitor and control behaviour checked
// cycle by cycle against hand-derived values.
module tb_fetch_queue_ctrl;

    localparam int IW = 12;
    localparam int AW = 8;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          reset_n_i;
    logic          deque_i;
    logic          restart_i;
    logic [AW-1:0] restart_addr_i;
    logic [IW-1:0] instruction_data_o;
    logic [AW-1:0] instruction_addr_o;
    logic          instruction_ready_o;
    logic          rom_en_o;
    logic [AW-1:0] rom_addr_o;
    logic [IW-1:0] rom_data_i;
    logic [$clog2(DP):0] count_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [AW-1:0] sb_q [$];
    logic          infl_m;

    always #5 clk = ~clk;

    fetch_queue_ctrl #(.I_WIDTH(IW), .A_WIDTH(AW), .DEPTH(DP)) dut (
        .clk                 (clk),
        .reset_n_i           (reset_n_i),
        .deque_i             (deque_i),
        .restart_i           (restart_i),
        .restart_addr_i      (restart_addr_i),
        .instruction_data_o  (instruction_data_o),
        .instruction_addr_o  (instruction_addr_o),
        .instruction_ready_o (instruction_ready_o),
        .rom_en_o            (rom_en_o),
        .rom_addr_o          (rom_addr_o),
        .rom_data_i          (rom_data_i),
        .count_o             (count_o)
    );

    // ROM contents: a fixed function of the address.
    function automatic logic [IW-1:0] rom_fn(input logic [AW-1:0] a);
        return {a[3:0], a ^ 8'h5A};
    endfunction

    // Synchronous ROM; returns a junk word when not read.
    always @(posedge clk) begin
        rom_data_i <= rom_en_o ? rom_fn(rom_addr_o) : 12'hBAD;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h at %0t", name, act, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_addr(input logic [AW-1:0] a);
        sb_q.push_back(a);
    endtask

    // Scoreboard monitor: every accepted pop is compared with the next
    // expected address and its ROM word.
    always @(negedge clk) begin
        if (reset_n_i && deque_i && !restart_i && instruction_ready_o) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pop: got addr %0h expected none", instruction_addr_o);
            end else begin
                logic [AW-1:0] ea;
                ea = sb_q.pop_front();
                check("pop_addr", 32'(instruction_addr_o), 32'(ea));
                check("pop_data", 32'(instruction_data_o), 32'(rom_fn(ea)));
            end
        end
    end

    // Reference in-flight flag: a read is outstanding the cycle after rom_en_o.
    always @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) infl_m <= 1'b0;
        else            infl_m <= rom_en_o;
    end

    // Occupancy invariant: count + inflight never exceeds DEPTH.
    always @(negedge clk) begin
        if (reset_n_i) begin
            n_cmp++;
            if (32'(count_o) + 32'(infl_m) > DP) begin
                n_err++;
                $display("FAIL occupancy: got %0d expected <= %0d", 32'(count_o) + 32'(infl_m), DP);
            end
        end
    end

    initial begin
        reset_n_i      = 1'b0;
        deque_i        = 1'b0;
        restart_i      = 1'b0;
        restart_addr_i = '0;

        // Reset state
        #2;
        check("rst_ready", 32'(instruction_ready_o), 0);
        check("rst_en",    32'(rom_en_o), 0);
        check("rst_raddr", 32'(rom_addr_o), 0);
        check("rst_count", 32'(count_o), 0);
        check("rst_data",  32'(instruction_data_o), 0);
        check("rst_addr",  32'(instruction_addr_o), 0);

        // Fill from reset: issues at 00..03, ready two cycles after first issue.
        @(posedge clk);
        #2;
        reset_n_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            check($sformatf("fill_en_c%0d", c),    32'(rom_en_o), (c < 4) ? 1 : 0);
            check($sformatf("fill_raddr_c%0d", c), 32'(rom_addr_o), (c < 4) ? c : 4);
            check($sformatf("fill_ready_c%0d", c), 32'(instruction_ready_o), (c >= 2) ? 1 : 0);
            check($sformatf("fill_count_c%0d", c), 32'(count_o), (c >= 2) ? (c - 1) : 0);
            tick();
        end
        #1;
        check("full_count", 32'(count_o), 4);
        check("full_en",    32'(rom_en_o), 0);
        check("full_head",  32'(instruction_addr_o), 0);
        check("full_data",  32'(instruction_data_o), 32'(rom_fn(8'h00)));

        // Pop five entries so the head becomes 05, then let the queue refill.
        for (int a = 0; a < 5; a++) expect_addr(AW'(a));
        deque_i = 1'b1;
        repeat (5) tick();
        deque_i = 1'b0;
        repeat (6) tick();
        #1;
        check("refill_count", 32'(count_o), 4);
        check("refill_head",  32'(instruction_addr_o), 5);
        check("refill_data",  32'(instruction_data_o), 32'(rom_fn(8'h05)));

        // Restart to 0x40 with a full queue.
        restart_i      = 1'b1;
        restart_addr_i = 8'h40;
        #1;
        check("rs40_en_r0", 32'(rom_en_o), 0);
        tick();
        restart_i = 1'b0;
        #1;
        check("rs40_ready_r1", 32'(instruction_ready_o), 0);
        check("rs40_count_r1", 32'(count_o), 0);
        check("rs40_en_r1",    32'(rom_en_o), 1);
        check("rs40_raddr_r1", 32'(rom_addr_o), 32'h40);
        tick();
        #1;
        check("rs40_ready_r2", 32'(instruction_ready_o), 0);
        tick();
        #1;
        check("rs40_ready_r3", 32'(instruction_ready_o), 1);
        check("rs40_head_r3",  32'(instruction_addr_o), 32'h40);
        check("rs40_data_r3",  32'(instruction_data_o), 32'(rom_fn(8'h40)));
        check("rs40_count_r3", 32'(count_o), 1);

        // Restart to 0x10 together with a deque; deque stays high.
        tick();
        restart_i      = 1'b1;
        restart_addr_i = 8'h10;
        deque_i        = 1'b1;
        expect_addr(8'h10);
        expect_addr(8'h11);
        expect_addr(8'h12);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) restart_i = 1'b0;
            #1;
            if (k <= 2) begin
                check($sformatf("rs10_count_k%0d", k), 32'(count_o), 0);
                check($sformatf("rs10_ready_k%0d", k), 32'(instruction_ready_o), 0);
            end else begin
                check($sformatf("rs10_ready_k%0d", k), 32'(instruction_ready_o), 1);
                check($sformatf("rs10_cnt_le2_k%0d", k), 32'(count_o <= 2), 1);
            end
        end

        // Restart to 0xFE with continuous deque: delivers FE, FF, 00, 01.
        tick();
        restart_i      = 1'b1;
        restart_addr_i = 8'hFE;
        expect_addr(8'hFE);
        expect_addr(8'hFF);
        expect_addr(8'h00);
        expect_addr(8'h01);
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) restart_i = 1'b0;
            if (k == 7) deque_i = 1'b0;
            #1;
            if (k >= 3 && k <= 6) begin
                check($sformatf("rsfe_ready_k%0d", k), 32'(instruction_ready_o), 1);
                check($sformatf("rsfe_cnt_le2_k%0d", k), 32'(count_o <= 2), 1);
            end
        end

        // Asynchronous reset between clock edges in mid-stream.
        tick();
        tick();
        #2;
        reset_n_i = 1'b0;
        #1;
        check("arst_ready", 32'(instruction_ready_o), 0);
        check("arst_en",    32'(rom_en_o), 0);
        check("arst_count", 32'(count_o), 0);
        check("arst_raddr", 32'(rom_addr_o), 0);
        check("arst_head",  32'(instruction_addr_o), 0);
        #4;
        reset_n_i = 1'b1;
        #1;
        check("rel_en",    32'(rom_en_o), 1);
        check("rel_raddr", 32'(rom_addr_o), 0);
        expect_addr(8'h00);
        expect_addr(8'h01);
        tick();
        tick();
        deque_i = 1'b1;
        #1;
        check("rel_ready_c2", 32'(instruction_ready_o), 1);
        tick();
        tick();
        deque_i = 1'b0;
        repeat (4) tick();

        check("sb_drained", 32'(sb_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
